// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU core: phase width and named phases, the
// sequencer state encoding, and a small helper used when leaving IDLE or
// HALTED.
package cpu_pkg;

    localparam int PHASE_W = 3;

    typedef logic [PHASE_W-1:0] phase_t;

    // One instruction walks through these eight phases in order.
    localparam phase_t PH_INST_ADDR  = 3'd0;
    localparam phase_t PH_INST_FETCH = 3'd1;
    localparam phase_t PH_INST_LOAD  = 3'd2;
    localparam phase_t PH_IDLE       = 3'd3;
    localparam phase_t PH_OP_ADDR    = 3'd4;
    localparam phase_t PH_OP_FETCH   = 3'd5;
    localparam phase_t PH_ALU_OP     = 3'd6;
    localparam phase_t PH_STORE      = 3'd7;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_RUN    = 2'd1,
        SEQ_PAUSE  = 2'd2,
        SEQ_HALTED = 2'd3
    } seq_state_e;

    // Leaving IDLE/HALTED lands in PAUSE when single-stepping, RUN otherwise.
    function automatic seq_state_e launch_state(input logic step_mode);
        return step_mode ? SEQ_PAUSE : SEQ_RUN;
    endfunction

endpackage

// File: rtl/phase_counter.sv
// 3-bit wrapping phase counter.
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset (counter -> 0)
//   en_i     advance by one (7 wraps to 0)
//   clr_i    synchronous clear to phase 0, takes priority over en_i
//   phase_o  current phase
module phase_counter
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en_i,
    input  logic   clr_i,
    output phase_t phase_o
);

    phase_t phase_q;
    phase_t phase_d;

    always_comb begin
        phase_d = phase_q;
        if (clr_i) begin
            phase_d = PH_INST_ADDR;
        end else if (en_i) begin
            phase_d = phase_q + phase_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_INST_ADDR;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/phase_sequencer.sv
// Phase sequencer: drives the 3-bit instruction phase into the controller,
// with run / halt / single-step control and a retired-instruction counter.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | after reset; phase held at 0, waits for start
//   RUN     | phase advances every clock, one instruction per 8 clocks
//   PAUSE   | single-step wait before a fetch; phase held at 0
//   HALTED  | controller executed HLT; phase frozen until start
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        leave IDLE or HALTED (ignored in RUN/PAUSE)
//   step_mode    1 = pause before every instruction fetch
//   step_req     execute one instruction while paused
//   halt         controller halt, only honoured at HALT_PHASE
//   phase        current phase
//   step_ack     one-cycle pulse accepting step_req
//   instr_done   phase-7 cycle of a completed instruction (combinational)
//   running      high in RUN (combinational)
//   halted       high in HALTED
//   instr_count  retired instructions, wraps
module phase_sequencer
    import cpu_pkg::*;
#(
    parameter int     CNT_W      = 16,
    parameter phase_t HALT_PHASE = 3'd4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step_req,
    input  logic             halt,
    output logic [2:0]       phase,
    output logic             step_ack,
    output logic             instr_done,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_q, ack_d;
    logic             halted_q, halted_d;
    logic             ph_en;
    logic             ph_clr;
    phase_t           phase_q;

    phase_counter u_phase_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (ph_en),
        .clr_i   (ph_clr),
        .phase_o (phase_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        ph_en   = 1'b0;
        ph_clr  = 1'b0;

        case (state_q)
            SEQ_IDLE: begin
                ph_clr = 1'b1;
                if (start) begin
                    state_d = launch_state(step_mode);
                end
            end

            SEQ_RUN: begin
                if ((phase_q == HALT_PHASE) && halt) begin
                    // HLT retires without reaching phase 7; phase stays put.
                    state_d = SEQ_HALTED;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else begin
                    ph_en = 1'b1;
                    if (phase_q == PH_STORE) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (step_mode) begin
                            state_d = SEQ_PAUSE;
                        end
                    end
                end
            end

            SEQ_PAUSE: begin
                ph_clr = 1'b1;
                // step_req has priority; start is never looked at here.
                if (step_req) begin
                    ack_d   = 1'b1;
                    state_d = SEQ_RUN;
                end else if (!step_mode) begin
                    state_d = SEQ_RUN;
                end
            end

            SEQ_HALTED: begin
                if (start) begin
                    ph_clr  = 1'b1;
                    state_d = launch_state(step_mode);
                end
            end

            default: begin
                ph_clr  = 1'b1;
                state_d = SEQ_IDLE;
            end
        endcase

        halted_d = (state_d == SEQ_HALTED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SEQ_IDLE;
            cnt_q    <= '0;
            ack_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            halted_q <= halted_d;
        end
    end

    assign phase       = phase_q;
    assign step_ack    = ack_q;
    assign halted      = halted_q;
    assign instr_count = cnt_q;
    assign running     = (state_q == SEQ_RUN);
    assign instr_done  = (state_q == SEQ_RUN) && (phase_q == PH_STORE);

endmodule

// File: tb/tb_phase_sequencer.sv
module tb_phase_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        step_mode;
    logic        step_req;
    logic        halt;
    logic [2:0]  phase;
    logic        step_ack;
    logic        instr_done;
    logic        running;
    logic        halted;
    logic [15:0] instr_count;

    phase_sequencer #(.CNT_W(16), .HALT_PHASE(3'd4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .step_mode   (step_mode),
        .step_req    (step_req),
        .halt        (halt),
        .phase       (phase),
        .step_ack    (step_ack),
        .instr_done  (instr_done),
        .running     (running),
        .halted      (halted),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 IDLE, 1 RUN, 2 PAUSE, 3 HALTED
    int          m_st;
    logic [2:0]  m_ph;
    logic [15:0] m_cnt;
    logic        m_ack;
    int          halt_mode;   // 0 never, 1 only at phase 4, 2 every phase except 4

    typedef struct {
        logic [2:0]  ph;
        logic [15:0] cnt;
        logic        ack;
        logic        run;
        logic        hlt;
        logic        done;
    } exp_t;

    exp_t sb[$];

    task automatic model_reset();
        m_st  = 0;
        m_ph  = 3'd0;
        m_cnt = 16'd0;
        m_ack = 1'b0;
    endtask

    task automatic model_step();
        m_ack = (m_st == 2) && step_req;
        if (m_st == 0) begin
            if (start) m_st = step_mode ? 2 : 1;
        end else if (m_st == 1) begin
            if (m_ph == 3'd4 && halt) begin
                m_st  = 3;
                m_cnt = m_cnt + 16'd1;
            end else if (m_ph == 3'd7) begin
                m_ph  = 3'd0;
                m_cnt = m_cnt + 16'd1;
                if (step_mode) m_st = 2;
            end else begin
                m_ph = m_ph + 3'd1;
            end
        end else if (m_st == 2) begin
            if (step_req || !step_mode) m_st = 1;
        end else begin
            if (start) begin
                m_ph = 3'd0;
                m_st = step_mode ? 2 : 1;
            end
        end
    endtask

    // One clock: derive halt from the model phase, predict, push, then
    // pop and compare just after the edge.
    task automatic cycle();
        exp_t e;
        halt = ((halt_mode == 1) && (m_ph == 3'd4)) ||
               ((halt_mode == 2) && (m_ph != 3'd4));
        model_step();
        e.ph   = m_ph;
        e.cnt  = m_cnt;
        e.ack  = m_ack;
        e.run  = (m_st == 1);
        e.hlt  = (m_st == 3);
        e.done = (m_st == 1) && (m_ph == 3'd7);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("sb_phase", {29'd0, phase}, {29'd0, e.ph});
        check("sb_count", {16'd0, instr_count}, {16'd0, e.cnt});
        check("sb_step_ack", {31'd0, step_ack}, {31'd0, e.ack});
        check("sb_running", {31'd0, running}, {31'd0, e.run});
        check("sb_halted", {31'd0, halted}, {31'd0, e.hlt});
        check("sb_instr_done", {31'd0, instr_done}, {31'd0, e.done});
    endtask

    task automatic pulse_cycle(input logic s, input logic r);
        start    = s;
        step_req = r;
        cycle();
        start    = 1'b0;
        step_req = 1'b0;
    endtask

    typedef struct {
        logic        start;
        logic        step_mode;
        logic        step_req;
        int          halt_mode;
        int          ncyc;
        logic [2:0]  exp_ph;
        logic [15:0] exp_cnt;
        logic        exp_run;
        logic        exp_halt;
    } seg_t;

    seg_t tbl[13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected < 2000000", $time);
        $fatal(1);
    end

    initial begin
        // start step_mode step_req halt_mode ncyc | phase count running halted
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 0,  1, 3'd0, 16'd0,  1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 0, 24, 3'd0, 16'd3,  1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 2, 16, 3'd0, 16'd5,  1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1, 25, 3'd4, 16'd6,  1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 0,  1, 3'd0, 16'd6,  1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 0,  8, 3'd0, 16'd7,  1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 0,  8, 3'd0, 16'd8,  1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 0,  5, 3'd0, 16'd8,  1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 0,  1, 3'd0, 16'd8,  1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 0,  8, 3'd0, 16'd9,  1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 0,  9, 3'd0, 16'd10, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 0,  1, 3'd0, 16'd10, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 0, 11, 3'd3, 16'd11, 1'b1, 1'b0};

        rst_n     = 1'b0;
        start     = 1'b0;
        step_mode = 1'b0;
        step_req  = 1'b0;
        halt      = 1'b0;
        halt_mode = 0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check("rst_phase", {29'd0, phase}, 32'd0);
        check("rst_count", {16'd0, instr_count}, 32'd0);
        check("rst_flags", {28'd0, step_ack, instr_done, running, halted}, 32'd0);
        rst_n = 1'b1;

        cycle();
        check("idle_hold_phase", {29'd0, phase}, 32'd0);
        check("idle_not_running", {31'd0, running}, 32'd0);

        for (int i = 0; i < 13; i++) begin
            step_mode = tbl[i].step_mode;
            halt_mode = tbl[i].halt_mode;
            start     = tbl[i].start;
            step_req  = tbl[i].step_req;
            for (int c = 0; c < tbl[i].ncyc; c++) begin
                cycle();
                start    = 1'b0;
                step_req = 1'b0;
            end
            check($sformatf("tbl%0d_phase", i), {29'd0, phase}, {29'd0, tbl[i].exp_ph});
            check($sformatf("tbl%0d_count", i), {16'd0, instr_count}, {16'd0, tbl[i].exp_cnt});
            check($sformatf("tbl%0d_running", i), {31'd0, running}, {31'd0, tbl[i].exp_run});
            check($sformatf("tbl%0d_halted", i), {31'd0, halted}, {31'd0, tbl[i].exp_halt});
        end

        // Asynchronous reset in the middle of a phase-5 cycle.
        halt_mode = 0;
        cycle();
        cycle();
        check("pre_rst_phase", {29'd0, phase}, 32'd5);
        check("pre_rst_count", {16'd0, instr_count}, 32'd11);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_phase", {29'd0, phase}, 32'd0);
        check("async_rst_count", {16'd0, instr_count}, 32'd0);
        check("async_rst_flags", {28'd0, step_ack, instr_done, running, halted}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Halt at phase 4 of the second instruction, then relaunch into PAUSE.
        pulse_cycle(1'b1, 1'b0);
        repeat (8) cycle();
        halt_mode = 1;
        repeat (25) cycle();
        check("halt2_phase", {29'd0, phase}, 32'd4);
        check("halt2_count", {16'd0, instr_count}, 32'd2);
        check("halt2_halted", {31'd0, halted}, 32'd1);
        halt_mode = 0;
        step_mode = 1'b1;
        pulse_cycle(1'b1, 1'b0);
        check("relaunch_pause_phase", {29'd0, phase}, 32'd0);
        check("relaunch_pause_running", {31'd0, running}, 32'd0);
        check("relaunch_pause_halted", {31'd0, halted}, 32'd0);
        pulse_cycle(1'b0, 1'b1);
        check("step_ack_pulse", {31'd0, step_ack}, 32'd1);
        repeat (8) cycle();
        check("step_done_count", {16'd0, instr_count}, 32'd3);
        check("step_back_pause", {31'd0, running}, 32'd0);
        repeat (3) cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
